// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
//   Single-clock parameterised FIFO with registered status flags, sticky
//   overflow/underflow error flags, synchronous flush and an optional
//   first-word-fall-through read port.
//
//   Optional feature macro: PARAM_SYNC_FIFO_HWM_EN
//     When defined, adds output o_hwm, the peak o_count since reset.
//     i_err_clr reloads it with the current count.
//
// Parameters
//   DATA_W  data width in bits
//   DEPTH   number of entries (power of two)
//   UPP_TH  almost-full margin  (o_alm_full  when count >= DEPTH-UPP_TH)
//   LOW_TH  almost-empty margin (o_alm_empty when count <= LOW_TH)
//   FWFT    0 = data one cycle after a read, 1 = head entry always shown
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   i_flush          empty the FIFO (error flags kept)
//   i_err_clr        clear o_ovf / o_udf (wins over a same-cycle set)
//   i_wren/i_wrdata  write request and data
//   i_rden           read request (FWFT: pop head)
//   o_rddata/o_rvalid read data and its valid
//   o_full, o_alm_full, o_alm_empty, o_empty  registered status flags
//   o_count          occupancy 0..DEPTH
//   o_ovf, o_udf     sticky overflow / underflow
// -----------------------------------------------------------------------------
module param_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int UPP_TH = 4,
    parameter int LOW_TH = 2,
    parameter int FWFT   = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_flush,
    input  logic                       i_err_clr,
    input  logic                       i_wren,
    input  logic [DATA_W-1:0]          i_wrdata,
    input  logic                       i_rden,
    output logic [DATA_W-1:0]          o_rddata,
    output logic                       o_rvalid,
    output logic                       o_full,
    output logic                       o_alm_full,
    output logic                       o_alm_empty,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_ovf,
    output logic                       o_udf
`ifdef PARAM_SYNC_FIFO_HWM_EN
    ,
    output logic [$clog2(DEPTH):0]     o_hwm
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - UPP_TH);
    localparam logic [CW-1:0] AEMPT_LVL = CW'(LOW_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              alm_full_q, alm_full_d;
    logic              alm_empty_q, alm_empty_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;
    logic              rvalid_q, rvalid_d;
    logic              wr_acc, rd_acc;

    // Accesses are decided from the registered flags; flush swallows both.
    // A read frees a slot, so a write at full is still accepted alongside it.
    always_comb begin
        rd_acc = i_rden && !empty_q && !i_flush;
        wr_acc = i_wren && (!full_q || rd_acc) && !i_flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(wr_acc);
            rd_ptr_d = rd_ptr_q + AW'(rd_acc);
            count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
            if (i_wren && !wr_acc) ovf_d = 1'b1;
            if (i_rden && empty_q) udf_d = 1'b1;
        end
        if (i_err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        // Flags come from the next count so they line up with o_count.
        full_d      = (count_d == FULL_LVL);
        alm_full_d  = (count_d >= AFULL_LVL);
        alm_empty_d = (count_d <= AEMPT_LVL);
        empty_d     = (count_d == '0);
    end

    if (FWFT != 0) begin : g_fwft
        logic [CW-1:0] occ_after_rd;
        // The output register tracks the head that will exist after this
        // edge. When the FIFO drains to nothing except the entry being
        // written now, that entry bypasses the memory.
        always_comb begin
            occ_after_rd = count_q - CW'(rd_acc);
            rddata_d     = rddata_q;
            rvalid_d     = !empty_d;
            if (!i_flush) begin
                if (wr_acc && (occ_after_rd == '0)) begin
                    rddata_d = i_wrdata;
                end else if (count_d != '0) begin
                    rddata_d = mem[rd_ptr_d];
                end
            end
        end
    end else begin : g_std
        always_comb begin
            rddata_d = rddata_q;
            rvalid_d = 1'b0;
            if (rd_acc) begin
                rddata_d = mem[rd_ptr_q];
                rvalid_d = 1'b1;
            end
        end
    end

    // Storage is never reset; reset still blocks a same-cycle write.
    always_ff @(posedge clk) begin
        if (rstn && wr_acc) begin
            mem[wr_ptr_q] <= i_wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            rddata_q    <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            alm_full_q  <= alm_full_d;
            alm_empty_q <= alm_empty_d;
            empty_q     <= empty_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            rddata_q    <= rddata_d;
            rvalid_q    <= rvalid_d;
        end
    end

`ifdef PARAM_SYNC_FIFO_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (i_err_clr) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) hwm_q <= '0;
        else       hwm_q <= hwm_d;
    end

    assign o_hwm = hwm_q;
`endif

    assign o_rddata    = rddata_q;
    assign o_rvalid    = rvalid_q;
    assign o_full      = full_q;
    assign o_alm_full  = alm_full_q;
    assign o_alm_empty = alm_empty_q;
    assign o_empty     = empty_q;
    assign o_count     = count_q;
    assign o_ovf       = ovf_q;
    assign o_udf       = udf_q;

endmodule
